// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the serial add/subtract unit.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/add_sub_cell.sv
// One-bit combinational add/subtract cell; carry and borrow share one chain signal.
module add_sub_cell
    import serial_arith_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cb_in,
    input  logic mode,
    output logic r,
    output logic cb_out
);

    assign r = x ^ y ^ cb_in;

    always_comb begin
        cb_out = 1'b0;
        if (mode == MODE_ADD) begin
            cb_out = (x & y) | (cb_in & (x ^ y));
        end else begin
            cb_out = (~x & y) | (~(x ^ y) & cb_in);
        end
    end

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed LSB-first, BPC bits per clock.
module serial_add_sub
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned STEPS = WIDTH / BPC;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    if ((WIDTH < 2) || ((WIDTH % BPC) != 0)) begin : g_param_err
        $error("serial_add_sub: WIDTH must be >= 2 and a multiple of BPC");
    end

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               step;
    logic               last_step;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH-1:0]   r_next;
    logic               mode_q;
    logic               a_msb;
    logic               b_msb;
    logic               cb_q;
    logic [BPC:0]       cb_chain;
    logic [BPC-1:0]     r_bits;
    logic               ovf_next;

    // Next-state and step control.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(STEPS - 1)) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // BPC cells ripple within a cycle; the chain end is registered in cb_q.
    assign cb_chain[0] = cb_q;
    for (genvar i = 0; i < BPC; i++) begin : g_cell
        add_sub_cell u_cell (
            .x      (a_sh[i]),
            .y      (b_sh[i]),
            .cb_in  (cb_chain[i]),
            .mode   (mode_q),
            .r      (r_bits[i]),
            .cb_out (cb_chain[i+1])
        );
    end

    // New bits enter at the MSB end so the word is aligned after the final step.
    assign r_next = (r_sh >> BPC) | (WIDTH'(r_bits) << (WIDTH - BPC));

    always_comb begin
        ovf_next = 1'b0;
        if (mode_q == MODE_ADD) begin
            ovf_next = (a_msb == b_msb) && (r_next[WIDTH-1] != a_msb);
        end else begin
            ovf_next = (a_msb != b_msb) && (r_next[WIDTH-1] != a_msb);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ready      <= 1'b1;
            done       <= 1'b0;
            cnt        <= '0;
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            mode_q     <= MODE_SUB;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            cb_q       <= 1'b0;
            result     <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state_next != RUN);
            done  <= (state_next == DONE);
            if (accept) begin
                a_sh   <= a;
                b_sh   <= b;
                mode_q <= mode;
                a_msb  <= a[WIDTH-1];
                b_msb  <= b[WIDTH-1];
                cb_q   <= 1'b0;
                cnt    <= '0;
            end else if (step) begin
                a_sh <= a_sh >> BPC;
                b_sh <= b_sh >> BPC;
                r_sh <= r_next;
                cb_q <= cb_chain[BPC];
                cnt  <= cnt + CNT_W'(1);
            end
            // Visible results change only when entering DONE.
            if (last_step) begin
                result     <= r_next;
                borrow_out <= cb_chain[BPC];
                overflow   <= ovf_next;
                zero       <= (r_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: 8-bit BPC=1, 8-bit BPC=4 and an exhaustive 4-bit sweep.
module tb_serial_add_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic [1:0]      start_v;
    logic [1:0]      mode_v;
    logic [1:0][7:0] a_v;
    logic [1:0][7:0] b_v;
    logic [1:0]      ready_v;
    logic [1:0]      done_v;
    logic [1:0][7:0] res_v;
    logic [1:0]      bo_v;
    logic [1:0]      ov_v;
    logic [1:0]      z_v;

    logic       start4, mode4, ready4, done4, bo4, ov4, z4;
    logic [3:0] a4, b4, res4;

    int n_tests = 0;
    int n_fail  = 0;

    serial_add_sub #(.WIDTH(8), .BPC(1)) u_b1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .mode(mode_v[0]),
        .a(a_v[0]), .b(b_v[0]), .ready(ready_v[0]), .done(done_v[0]),
        .result(res_v[0]), .borrow_out(bo_v[0]), .overflow(ov_v[0]), .zero(z_v[0])
    );

    serial_add_sub #(.WIDTH(8), .BPC(4)) u_b4 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .mode(mode_v[1]),
        .a(a_v[1]), .b(b_v[1]), .ready(ready_v[1]), .done(done_v[1]),
        .result(res_v[1]), .borrow_out(bo_v[1]), .overflow(ov_v[1]), .zero(z_v[1])
    );

    serial_add_sub #(.WIDTH(4), .BPC(1)) u_w4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .mode(mode4),
        .a(a4), .b(b4), .ready(ready4), .done(done4),
        .result(res4), .borrow_out(bo4), .overflow(ov4), .zero(z4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after an edge; start is held across exactly one edge.
    task automatic launch(input int u, input logic m, input logic [7:0] a, input logic [7:0] b);
        start_v[u] = 1'b1;
        mode_v[u]  = m;
        a_v[u]     = a;
        b_v[u]     = b;
        @(posedge clk); #1;
        start_v[u] = 1'b0;
    endtask

    task automatic wait_done(input int u, output int lat);
        lat = 0;
        while (!done_v[u] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic count_done(input int u, input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done_v[u]) n++;
        end
    endtask

    task automatic op8(input string tag, input int u, input logic m,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic [2:0] eflags, input int elat);
        int lat;
        launch(u, m, a, b);
        check({tag, "_ready_run"}, 32'(ready_v[u]), 32'd0);
        wait_done(u, lat);
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_result"}, 32'(res_v[u]), 32'(er));
        check({tag, "_bo_ov_z"}, 32'({bo_v[u], ov_v[u], z_v[u]}), 32'(eflags));
    endtask

    initial begin
        int lat;
        int n;
        logic [4:0] sum;
        logic [3:0] er;
        logic       ebo, eov;

        reset_n = 1'b0;
        start_v = '0; mode_v = '0; a_v = '0; b_v = '0;
        start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_v[0]), 32'd1);
        check("rst_done", 32'(done_v[0]), 32'd0);
        check("rst_result", 32'(res_v[0]), 32'd0);
        check("rst_flags", 32'({bo_v[0], ov_v[0], z_v[0]}), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed 8-bit, one bit per clock
        op8("sub_05_03", 0, 1'b0, 8'h05, 8'h03, 8'h02, 3'b000, 8);
        @(posedge clk); #1;
        check("done_pulse", 32'(done_v[0]), 32'd0);
        check("idle_ready", 32'(ready_v[0]), 32'd1);
        op8("sub_03_05", 0, 1'b0, 8'h03, 8'h05, 8'hFE, 3'b100, 8);
        op8("sub_80_01", 0, 1'b0, 8'h80, 8'h01, 8'h7F, 3'b010, 8);
        op8("add_FF_01", 0, 1'b1, 8'hFF, 8'h01, 8'h00, 3'b101, 8);
        op8("add_7F_01", 0, 1'b1, 8'h7F, 8'h01, 8'h80, 3'b010, 8);

        // Start mid-RUN must be ignored; previous result held during RUN
        launch(0, 1'b0, 8'h05, 8'h03);
        repeat (3) begin @(posedge clk); #1; end
        check("run_hold_result", 32'(res_v[0]), 32'h80);
        check("run_hold_ovf", 32'(ov_v[0]), 32'd1);
        launch(0, 1'b1, 8'hAA, 8'h11);
        wait_done(0, lat);
        check("midrun_latency", 32'(lat), 32'd4);
        check("midrun_result", 32'(res_v[0]), 32'h02);
        check("midrun_flags", 32'({bo_v[0], ov_v[0], z_v[0]}), 32'd0);
        count_done(0, 12, n);
        check("midrun_extra_done", 32'(n), 32'd0);
        check("midrun_result_held", 32'(res_v[0]), 32'h02);

        // Reset during step 4 discards the operation
        launch(0, 1'b1, 8'h10, 8'h20);
        repeat (4) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midrst_result", 32'(res_v[0]), 32'd0);
        check("midrst_flags", 32'({bo_v[0], ov_v[0], z_v[0]}), 32'd0);
        check("midrst_ready", 32'(ready_v[0]), 32'd1);
        check("midrst_done", 32'(done_v[0]), 32'd0);
        count_done(0, 12, n);
        check("midrst_no_done", 32'(n), 32'd0);
        op8("post_rst_add", 0, 1'b1, 8'h10, 8'h20, 8'h30, 3'b000, 8);

        // Four bits per clock, with a back-to-back start while in DONE
        op8("b4_sub_10_01", 1, 1'b0, 8'h10, 8'h01, 8'h0F, 3'b000, 2);
        check("b4_ready_done", 32'(ready_v[1]), 32'd1);
        op8("b4_b2b_add", 1, 1'b1, 8'h12, 8'h34, 8'h46, 3'b000, 2);
        op8("b4_sub_00_01", 1, 1'b0, 8'h00, 8'h01, 8'hFF, 3'b100, 2);

        // Exhaustive 4-bit sweep against an arithmetic model
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    if (m == 1) begin
                        sum = 5'(a) + 5'(b);
                        er  = sum[3:0];
                        ebo = sum[4];
                        eov = (a[3] == b[3]) && (er[3] != a[3]);
                    end else begin
                        sum = 5'(a) - 5'(b);
                        er  = sum[3:0];
                        ebo = (a < b);
                        eov = (a[3] != b[3]) && (er[3] != a[3]);
                    end
                    start4 = 1'b1; mode4 = m[0]; a4 = 4'(a); b4 = 4'(b);
                    @(posedge clk); #1;
                    start4 = 1'b0;
                    lat = 0;
                    while (!done4 && lat < 20) begin
                        @(posedge clk); #1;
                        lat++;
                    end
                    check($sformatf("w4_m%0d_a%0h_b%0h", m, a, b),
                          {20'd0, 5'(lat), res4, bo4, ov4, z4},
                          {20'd0, 5'd4, er, ebo, eov, (er == 4'd0)});
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
